// File: rtl/opb_reg_bank.sv
// opb_reg_bank: OPB slave window with four RW control words and four RO status words.
// Defining OPB_REG_BANK_WAIT_EN inserts C_WAIT_CYCLES wait states before each ack.
module opb_reg_bank #(
  parameter logic [0:31] C_BASEADDR = 32'h0001_0000,
  parameter int C_WAIT_CYCLES = 2
) (
  input  logic          OPB_Clk,
  input  logic          OPB_Rst,
  input  logic [0:31]   OPB_ABus,
  input  logic [0:3]    OPB_BE,
  input  logic [0:31]   OPB_DBus,
  input  logic          OPB_RNW,
  input  logic          OPB_select,
  input  logic          OPB_seqAddr,
  output logic [0:31]   Sl_DBus,
  output logic          Sl_xferAck,
  output logic          Sl_errAck,
  output logic          Sl_retry,
  output logic          Sl_toutSup,
  output logic [0:127]  ctrl_reg,
  output logic [0:3]    ctrl_wr_stb,
  input  logic [0:127]  status_in
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;
  state_t state, next;
  logic hit, go_ack, wr, unused;
  logic [1:0] sel;
  logic [0:31] rdata;
  assign unused = ^{OPB_seqAddr, OPB_ABus[30:31]};
  assign hit = OPB_select && OPB_ABus[0:26] == C_BASEADDR[0:26];
  assign sel = OPB_ABus[28:29];
  assign rdata = OPB_ABus[27] ? status_in[{sel, 5'b0} +: 32] : ctrl_reg[{sel, 5'b0} +: 32];
  assign go_ack = next == ACK;
  assign wr = go_ack && !OPB_RNW && !OPB_ABus[27];
  assign Sl_xferAck = state == ACK;
  assign Sl_errAck = 1'b0;
  assign Sl_retry = 1'b0;
`ifdef OPB_REG_BANK_WAIT_EN
  logic [3:0] cnt;
  logic done;
  assign done = cnt == 4'(C_WAIT_CYCLES - 1);
  assign Sl_toutSup = state == WAIT;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = hit ? WAIT : IDLE;
      WAIT: next = !OPB_select ? IDLE : done ? ACK : WAIT;
      ACK: next = HOLD;
      default: next = OPB_select ? HOLD : IDLE;
    endcase
  end
  always_ff @(posedge OPB_Clk or posedge OPB_Rst)
    if (OPB_Rst) cnt <= '0;
    else cnt <= state == WAIT ? cnt + 4'd1 : 4'd0;
`else
  assign Sl_toutSup = 1'b0;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = hit ? ACK : IDLE;
      ACK: next = HOLD;
      default: next = OPB_select ? HOLD : IDLE;
    endcase
  end
`endif
  // Read data, strobes and register writes all land on the edge that enters ACK.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst)
    if (OPB_Rst) begin
      state <= IDLE;
      ctrl_reg <= '0;
      ctrl_wr_stb <= '0;
      Sl_DBus <= '0;
    end else begin
      state <= next;
      Sl_DBus <= go_ack && OPB_RNW ? rdata : 32'h0;
      ctrl_wr_stb <= wr ? 4'b1000 >> sel : 4'b0000;
      if (wr)
        for (int b = 0; b < 4; b++)
          if (OPB_BE[b]) ctrl_reg[{sel, b[1:0], 3'b0} +: 8] <= OPB_DBus[{b[1:0], 3'b0} +: 8];
    end
endmodule

// File: tb/tb_opb_reg_bank.sv
// tb_opb_reg_bank: table-driven directed checks of opb_reg_bank, plus early-drop and reset corner cases.
module tb_opb_reg_bank;
`ifdef OPB_REG_BANK_WAIT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [0:31] abus = '0, wdat = '0, Sl_DBus;
  logic [0:3] be = '0, ctrl_wr_stb;
  logic rnw = 1'b0, sel = 1'b0, seq = 1'b0;
  logic Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [0:127] ctrl_reg;
  logic [0:127] status = {32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFEED_FACE};
  int total = 0, bad = 0;

  opb_reg_bank #(.C_BASEADDR(32'h0001_0000), .C_WAIT_CYCLES(3)) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(wdat),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(Sl_DBus),
    .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
    .Sl_toutSup(Sl_toutSup), .ctrl_reg(ctrl_reg), .ctrl_wr_stb(ctrl_wr_stb),
    .status_in(status)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  typedef struct {
    logic rnw; logic [0:31] addr; logic [0:3] be; logic [0:31] wd;
    int acks; logic [0:3] stb; logic [0:31] dbus; int ridx; logic [0:31] rval;
  } vec_t;
  vec_t v[15];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int i);
    return ctrl_reg[{i[1:0], 5'b0} +: 32];
  endfunction

  task automatic xfer(input logic r, input logic [0:31] a, input logic [0:3] b, input logic [0:31] d,
                      input int hold, output int na, output int nl, output int nt, output int nn,
                      output logic [0:3] ws, output logic [0:31] rdd);
    na = 0; nl = 0; nt = 0; nn = 0; ws = '0; rdd = '0;
    @(negedge clk);
    rnw = r; abus = a; be = b; wdat = d; sel = 1'b1;
    for (int c = 1; c <= hold; c++) begin
      @(negedge clk);
      nt += int'(Sl_toutSup);
      if (Sl_xferAck) begin
        na++;
        if (na == 1) begin nl = c; ws = ctrl_wr_stb; rdd = Sl_DBus; end
      end else if (Sl_DBus != 0 || ctrl_wr_stb != 0) nn++;
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int na, nl, nt, nn, n;
    logic [0:3] ws;
    logic [0:31] rdd;
    v[0]  = '{1'b0, 32'h0001_0000, 4'b1111, 32'hAAAA_AAAA, 1, 4'b1000, 32'h0, 0, 32'hAAAA_AAAA};
    v[1]  = '{1'b0, 32'h0001_0000, 4'b0101, 32'h1122_3344, 1, 4'b1000, 32'h0, 0, 32'hAA22_AA44};
    v[2]  = '{1'b0, 32'h0001_0004, 4'b1111, 32'hDEAD_BEEF, 1, 4'b0100, 32'h0, 1, 32'hDEAD_BEEF};
    v[3]  = '{1'b0, 32'h0001_000C, 4'b0000, 32'h5555_5555, 1, 4'b0001, 32'h0, 3, 32'h0};
    v[4]  = '{1'b0, 32'h0001_0008, 4'b1000, 32'hCAFE_F00D, 1, 4'b0010, 32'h0, 2, 32'hCA00_0000};
    v[5]  = '{1'b0, 32'h0001_0014, 4'b1111, 32'hFFFF_FFFF, 1, 4'b0000, 32'h0, 1, 32'hDEAD_BEEF};
    v[6]  = '{1'b0, 32'h0001_001C, 4'b0011, 32'h7777_7777, 1, 4'b0000, 32'h0, 3, 32'h0};
    v[7]  = '{1'b1, 32'h0001_0014, 4'b1111, 32'h0, 1, 4'b0000, 32'h1234_5678, 1, 32'hDEAD_BEEF};
    v[8]  = '{1'b1, 32'h0001_0004, 4'b0000, 32'h0, 1, 4'b0000, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    v[9]  = '{1'b1, 32'h0001_0000, 4'b1111, 32'h0, 1, 4'b0000, 32'hAA22_AA44, 0, 32'hAA22_AA44};
    v[10] = '{1'b1, 32'h0001_001C, 4'b1111, 32'h0, 1, 4'b0000, 32'hFEED_FACE, 2, 32'hCA00_0000};
    v[11] = '{1'b1, 32'h0001_0008, 4'b0110, 32'h0, 1, 4'b0000, 32'hCA00_0000, 2, 32'hCA00_0000};
    v[12] = '{1'b0, 32'h0001_0020, 4'b1111, 32'h9999_9999, 0, 4'b0000, 32'h0, 0, 32'hAA22_AA44};
    v[13] = '{1'b1, 32'h0001_0020, 4'b1111, 32'h0, 0, 4'b0000, 32'h0, 0, 32'hAA22_AA44};
    v[14] = '{1'b0, 32'h0001_0018, 4'b1111, 32'h0123_4567, 1, 4'b0000, 32'h0, 2, 32'hCA00_0000};
    repeat (2) @(negedge clk);
    chk("rst ack", 32'(Sl_xferAck), 0);
    chk("rst dbus", Sl_DBus, 0);
    chk("rst stb", 32'(ctrl_wr_stb), 0);
    chk("rst tout", 32'(Sl_toutSup), 0);
    chk("rst regs", 32'(|ctrl_reg), 0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      xfer(v[i].rnw, v[i].addr, v[i].be, v[i].wd, v[i].acks != 0 ? LAT + 5 : 16, na, nl, nt, nn, ws, rdd);
      chk($sformatf("v%0d acks", i), 32'(na), 32'(v[i].acks));
      if (v[i].acks != 0) chk($sformatf("v%0d latency", i), 32'(nl), 32'(LAT));
      chk($sformatf("v%0d toutsup", i), 32'(nt), v[i].acks != 0 ? 32'(LAT - 1) : 32'd0);
      chk($sformatf("v%0d strobe", i), 32'(ws), 32'(v[i].stb));
      chk($sformatf("v%0d dbus", i), rdd, v[i].dbus);
      chk($sformatf("v%0d idle outputs", i), 32'(nn), 0);
      chk($sformatf("v%0d reg%0d", i, v[i].ridx), rd(v[i].ridx), v[i].rval);
    end
`ifdef OPB_REG_BANK_WAIT_EN
    xfer(1'b0, 32'h0001_0000, 4'b1111, 32'h0, 1, na, nl, nt, nn, ws, rdd);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      na += int'(Sl_xferAck);
    end
    chk("drop acks", 32'(na), 0);
    chk("drop reg0", rd(0), 32'hAA22_AA44);
`endif
    @(negedge clk);
    rnw = 1'b0; abus = 32'h0001_0008; be = 4'b1111; wdat = 32'h1357_2468; sel = 1'b1;
    n = 0;
    while (!Sl_xferAck && n < 20) begin @(negedge clk); n++; end
    chk("rstmid ack seen", 32'(Sl_xferAck), 1);
    rst = 1'b1;
    #1;
    chk("rstmid ack", 32'(Sl_xferAck), 0);
    chk("rstmid dbus", Sl_DBus, 0);
    chk("rstmid stb", 32'(ctrl_wr_stb), 0);
    chk("rstmid tout", 32'(Sl_toutSup), 0);
    chk("rstmid regs", 32'(|ctrl_reg), 0);
    @(negedge clk);
    rst = 1'b0;
    na = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      na += int'(Sl_xferAck);
    end
    chk("rehit acks", 32'(na), 1);
    chk("rehit reg2", rd(2), 32'h1357_2468);
    chk("rehit reg0", rd(0), 0);
    sel = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/opb_reg_bank.md
OPB_REG_BANK -- requirements
Module: opb_reg_bank

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h0001_0000, the base of the 32-byte slave window; bits [27:31] are zero.
REQ-002 SHALL have parameter C_WAIT_CYCLES, default 2, the extra ack wait states (range 1-15); it is used only when OPB_REG_BANK_WAIT_EN is defined.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with these ports:
- OPB_Clk  in  1  sole clock; all state changes on its rising edge.
- OPB_Rst  in  1  asynchronous active-high reset.
- OPB_ABus  in  [0:31]  address from the OPB master (EPB bridge).
- OPB_BE  in  [0:3]  byte enables; bit 0 = OPB_DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer in progress.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero unless Sl_xferAck is high.
- Sl_xferAck  out  1  transfer acknowledge, one-cycle pulse.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  timeout suppress.
- ctrl_reg  out  [0:127]  four RW registers; reg0 = [0:31].
- ctrl_wr_stb  out  [0:3]  one-cycle pulse per RW register written.
- status_in  in  [0:127]  four RO words; word0 = [0:31].

Function
REQ-004 SHALL decode a hit when OPB_select=1 and OPB_ABus[0:26]==C_BASEADDR[0:26]; index = OPB_ABus[27:29], where 0-3 are RW ctrl and 4-7 are RO status.
REQ-005 SHALL implement FSM states IDLE, WAIT, ACK, HOLD; reset state IDLE.
REQ-006 SHALL transition IDLE->ACK on a hit (macro absent) or IDLE->WAIT (macro present); a non-hit stays IDLE and produces no response.
REQ-007 SHALL, in ACK, drive Sl_xferAck=1 for exactly one cycle, then go to HOLD.
REQ-008 SHALL remain in HOLD with Sl_xferAck=0 until OPB_select=0, then go to IDLE; there is no second ack within one select assertion.
REQ-009 SHALL give one-cycle latency without the macro: a hit sampled at edge N asserts Sl_xferAck in the cycle after edge N.
REQ-010 SHALL, on a write, update only lanes with OPB_BE=1 on the same edge that asserts Sl_xferAck, and pulse ctrl_wr_stb[index] in that same cycle; BE=0000 acks with no change but still strobes.
REQ-011 SHALL ack writes to RO indices 4-7 with no state change and no strobe.
REQ-012 SHALL, on a read, register Sl_DBus from ctrl_reg or status_in at the edge entering ACK; status is sampled there.
REQ-013 SHALL return to IDLE with no write, no strobe and no ack if OPB_select drops in WAIT or ACK-entry.
REQ-014 SHALL drive Sl_toutSup=1 in WAIT and 0 otherwise.
REQ-015 SHALL ignore OPB_BE on reads; a full word is always returned.

Reset
REQ-016 SHALL, while OPB_Rst=1, force asynchronously: FSM IDLE, ctrl_reg all 0, ctrl_wr_stb 0, Sl_DBus 0, Sl_xferAck 0, Sl_toutSup 0, wait counter 0.
REQ-017 SHALL abandon any transfer in progress on reset mid-transfer; after release the FSM waits in IDLE for a fresh hit; a select still high from before reset counts as a new hit.

Configuration
REQ-018 SHALL, with OPB_REG_BANK_WAIT_EN defined, pass through WAIT, counting C_WAIT_CYCLES cycles, then ACK; ack latency = C_WAIT_CYCLES+1.
REQ-019 SHALL, without OPB_REG_BANK_WAIT_EN, omit WAIT and the counter entirely; Sl_toutSup is constant 0 and latency is 1.

Verification
REQ-020 SHALL cover: write 0xDEADBEEF, BE=1111, to base+0x4 -> ack 1 cycle later, ctrl_reg[32:63]=0xDEADBEEF, ctrl_wr_stb=0100 for one cycle.
REQ-021 SHALL cover: write 0x11223344, BE=0101, to base+0x0 preloaded 0xAAAAAAAA -> reg0=0xAA22AA44.
REQ-022 SHALL cover: read base+0x14 with status_in word1=0x12345678 -> Sl_DBus=0x12345678 only during ack; Sl_DBus=0 otherwise.
REQ-023 SHALL cover: select held 6 cycles on a hit -> exactly one ack; a miss at base+0x20 -> no ack for 16 cycles.
REQ-024 SHALL cover: macro defined, C_WAIT_CYCLES=3 -> ack in the 4th cycle, Sl_toutSup high for 3 cycles; select dropped after 1 cycle -> no ack, register unchanged.
REQ-025 SHALL cover: OPB_Rst pulsed in the ack cycle of a write -> all outputs 0, registers 0.
